// File: rtl/wired_mul_pkg.sv
// Shared definitions for the iterative multiplier and the decode logic that
// selects its sign controls and result half.
package wired_mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_LAT   = MUL_WIDTH;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_e;

  typedef struct packed {
    logic sign_a;
    logic sign_b;
    logic select_hi;
  } mul_ctrl_t;

  // Low half of the product is identical for every signedness, so MUL
  // simply reuses the signed/signed setting.
  function automatic mul_ctrl_t mul_op_ctrl(input mul_op_e op);
    mul_ctrl_t c;
    c = '{sign_a: 1'b1, sign_b: 1'b1, select_hi: 1'b0};
    case (op)
      MUL:    c = '{sign_a: 1'b1, sign_b: 1'b1, select_hi: 1'b0};
      MULH:   c = '{sign_a: 1'b1, sign_b: 1'b1, select_hi: 1'b1};
      MULHSU: c = '{sign_a: 1'b1, sign_b: 1'b0, select_hi: 1'b1};
      MULHU:  c = '{sign_a: 1'b0, sign_b: 1'b0, select_hi: 1'b1};
      default: c = '{sign_a: 1'b1, sign_b: 1'b1, select_hi: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/wired_mul32_simp.sv
// Fixed-latency radix-2 shift-add multiplier. Operands are reduced to
// magnitudes on start, multiplied unsigned over WIDTH iterations, and the
// sign is reapplied combinationally on the way out.
module wired_mul32_simp
  import wired_mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             sign_a,
  input  logic             sign_b,
  input  logic             start,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] prod_hi
);

  localparam int TW = $clog2(WIDTH + 1);

  logic [TW-1:0]      timer_q;
  logic               busy_q;
  logic               done_q;
  logic               neg_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH:0]     acc_q;

  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] raw;
  logic [2*WIDTH-1:0] prod;
  logic               last_iter;

  // Operand magnitudes; the most negative value maps onto itself, which is
  // the correct unsigned magnitude 2^(WIDTH-1).
  always_comb begin
    a_neg = sign_a & A[WIDTH-1];
    b_neg = sign_b & B[WIDTH-1];
    a_abs = a_neg ? (~A + 1'b1) : A;
    b_abs = b_neg ? (~B + 1'b1) : B;
  end

  // One partial-product add per iteration, with a carry bit kept in acc_q.
  always_comb begin
    sum       = acc_q + {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
    last_iter = (timer_q == TW'(1));
  end

  // Control: down-counting iteration timer with busy/done handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (flush) begin
      timer_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (start) begin
      timer_q <= TW'(WIDTH);
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else if (timer_q != '0) begin
      timer_q <= timer_q - 1'b1;
      busy_q  <= ~last_iter;
      done_q  <= last_iter;
    end else begin
      done_q  <= 1'b0;
    end
  end

  // Datapath: operand capture on start, then shift {acc, mplier} right each
  // iteration so the product's low bits fill the multiplier register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (flush) begin
      neg_q    <= neg_q;
    end else if (start) begin
      neg_q    <= a_neg ^ b_neg;
      mcand_q  <= a_abs;
      mplier_q <= b_abs;
      acc_q    <= '0;
    end else if (timer_q != '0) begin
      acc_q    <= {1'b0, sum[WIDTH:1]};
      mplier_q <= {sum[0], mplier_q[WIDTH-1:1]};
    end
  end

  // Reapply the sign to the unsigned product, modulo 2^(2*WIDTH).
  always_comb begin
    raw  = {acc_q[WIDTH-1:0], mplier_q};
    prod = neg_q ? (~raw + 1'b1) : raw;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign prod_lo = prod[WIDTH-1:0];
  assign prod_hi = prod[2*WIDTH-1:WIDTH];

endmodule
